// File: rtl/cmd_tx.sv
// cmd_tx: serial command transmitter driving the one-wire `transmission` link.
//
// A command is a 4-bit data nibble plus a 4-bit instruction nibble, taken over a
// valid/ready handshake into a one-entry holding buffer. Each frame on the wire is:
// one low start bit, data bits 0..3, instruction bits 0..3, then STOP_CYCLES
// idle-high guard cycles. One bit is sent per clk2 cycle. After reset the line is
// held high for 11 cycles so the (reset-less) receiver flushes any partial frame.
//
// Parameters:
//   STOP_CYCLES  idle-high cycles after the last instruction bit (legal 2..15)
//   STRICT       1: reject instruction codes other than 1, 2 and 4 at accept
// Ports:
//   clk2          clock, rising edge
//   rst_n         asynchronous active-low reset
//   cmd_valid     command offered
//   cmd_data      data nibble
//   cmd_instr     instruction nibble
//   cmd_ready     holding buffer empty and post-reset quiet period over
//   transmission  registered serial line, idle high
//   busy          frame on the wire or buffer occupied
//   done          one-cycle pulse during the final stop cycle of each frame
//   err           one-cycle pulse the cycle after a rejected command

module cmd_tx #(
    parameter int unsigned STOP_CYCLES = 2,
    parameter bit          STRICT      = 1'b1
) (
    input  logic       clk2,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_data,
    input  logic [3:0] cmd_instr,
    output logic       cmd_ready,
    output logic       transmission,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StQuiet,
        StIdle,
        StStart,
        StData,
        StInstr,
        StStop
    } state_e;

    // Quiet period is 11 cycles: counter values 0..10.
    localparam logic [3:0] QuietLast = 4'd10;
    // Counter is 4 bits, so STOP_CYCLES must stay within 2..15.
    localparam logic [3:0] StopLast  = 4'(STOP_CYCLES - 1);
    localparam logic [3:0] DataLast  = 4'd3;
    localparam logic [3:0] InstrLast = 4'd7;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       tx_q, tx_d;
    logic       err_q, err_d;

    logic       accept;
    logic       instr_legal;
    logic       load_frame;

    assign cmd_ready    = !buf_full_q && (state_q != StQuiet);
    assign accept       = cmd_valid && cmd_ready;
    assign instr_legal  = !STRICT || (cmd_instr == 4'd1) || (cmd_instr == 4'd2)
                          || (cmd_instr == 4'd4);

    assign transmission = tx_q;
    assign err          = err_q;
    assign done         = (state_q == StStop) && (cnt_q == StopLast);
    assign busy         = buf_full_q || (state_q == StStart) || (state_q == StData)
                          || (state_q == StInstr) || (state_q == StStop);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_d       = tx_q;
        err_d      = 1'b0;
        load_frame = 1'b0;

        // Accept requires an empty buffer and a frame load requires a full one,
        // so the two never collide on the same edge.
        if (accept) begin
            if (instr_legal) begin
                buf_d      = {cmd_instr, cmd_data};
                buf_full_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // tx_d is the line value for the cycle after this edge, i.e. it follows
        // the state being entered, which keeps the line itself a plain flop.
        unique case (state_q)
            StQuiet: begin
                tx_d = 1'b1;
                if (cnt_q == QuietLast) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StIdle: begin
                tx_d = 1'b1;
                if (buf_full_q) begin
                    load_frame = 1'b1;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = 4'd0;
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[7:1]};
            end
            StData: begin
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[7:1]};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == DataLast) begin
                    state_d = StInstr;
                end
            end
            StInstr: begin
                if (cnt_q == InstrLast) begin
                    state_d = StStop;
                    cnt_d   = 4'd0;
                    tx_d    = 1'b1;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[7:1]};
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (cnt_q == StopLast) begin
                    cnt_d = 4'd0;
                    if (buf_full_q) begin
                        // Back-to-back: next start bit follows the last stop cycle.
                        load_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StQuiet;
                cnt_d   = 4'd0;
                tx_d    = 1'b1;
            end
        endcase

        if (load_frame) begin
            state_d    = StStart;
            cnt_d      = 4'd0;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            tx_d       = 1'b0;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StQuiet;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
            tx_q       <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            tx_q       <= tx_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cmd_tx.sv
// tb_cmd_tx: directed bench for cmd_tx.
// Instance dut:  default parameters (STOP_CYCLES=2, STRICT=1), followed by a
//                small receiver model that decodes frames off the line.
// Instance dut2: STOP_CYCLES=5, STRICT=0, used for verbatim sending and spacing.

module tb_cmd_tx;

    logic       clk2 = 1'b0;
    logic       rst_n;

    logic       v, ready, line, busy, done, err;
    logic [3:0] d, i;
    logic       v2, ready2, line2, busy2, done2, err2;
    logic [3:0] d2, i2;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk2 = ~clk2;

    cmd_tx dut (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .cmd_valid    (v),
        .cmd_data     (d),
        .cmd_instr    (i),
        .cmd_ready    (ready),
        .transmission (line),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    cmd_tx #(
        .STOP_CYCLES (5),
        .STRICT      (1'b0)
    ) dut2 (
        .clk2         (clk2),
        .rst_n        (rst_n),
        .cmd_valid    (v2),
        .cmd_data     (d2),
        .cmd_instr    (i2),
        .cmd_ready    (ready2),
        .transmission (line2),
        .busy         (busy2),
        .done         (done2),
        .err          (err2)
    );

    // Receiver model: no reset, samples mid-cycle, 1 = clean, 2 = store, 4 = show.
    logic       rx_active = 1'b0;
    logic [3:0] rx_cnt    = 4'd0;
    logic [7:0] rx_sh     = 8'd0;
    logic [3:0] rx_store  = 4'd0;
    logic [3:0] rx_disp   = 4'd0;
    logic [7:0] rx_word;

    assign rx_word = {line, rx_sh[7:1]};

    always @(negedge clk2) begin
        if (!rx_active) begin
            if (line === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 4'd0;
            end
        end else begin
            rx_sh <= rx_word;
            if (rx_cnt == 4'd7) begin
                rx_active <= 1'b0;
                case (rx_word[7:4])
                    4'd1: begin
                        rx_store <= 4'd0;
                        rx_disp  <= 4'd0;
                    end
                    4'd2: rx_store <= rx_word[3:0];
                    4'd4: rx_disp  <= rx_word[3:0];
                    default: ;
                endcase
            end else begin
                rx_cnt <= rx_cnt + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk2);
    endtask

    logic [31:0] lv, dv, bv;
    int          cnt_a, cnt_b;

    initial begin
        rst_n = 1'b0;
        v = 1'b1; d = 4'hA; i = 4'h2;
        v2 = 1'b0; d2 = 4'h0; i2 = 4'h0;

        // Reset state
        tick();
        chk("rst_line", 32'(line), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_line2", 32'(line2), 32'd1);
        tick();
        rst_n = 1'b1;

        // Quiet period with cmd_valid held high
        cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ready !== 1'b0) cnt_a++;
            if (line !== 1'b1) cnt_b++;
        end
        chk("quiet_ready_low", 32'(cnt_a), 32'd0);
        chk("quiet_line_high", 32'(cnt_b), 32'd0);
        tick();
        chk("quiet_ready_rise", 32'(ready), 32'd1);
        tick();
        chk("accept_ready", 32'(ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_line", 32'(line), 32'd1);
        v = 1'b0;

        // Frame (0xA, 2): 0,0,1,0,1,0,1,0,0,1,1
        lv = '0; dv = '0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            lv[n-1] = line;
            dv[n-1] = done;
        end
        chk("frame_a2_line", lv, 32'b11001010100);
        chk("frame_a2_done", dv, 32'b10000000000);
        tick();
        chk("frame_a2_busy_fall", 32'(busy), 32'd0);
        chk("rx_store_a", 32'(rx_store), 32'hA);

        // Back-to-back (0x5, 2) then (0x5, 4)
        v = 1'b1; d = 4'h5; i = 4'h2;
        lv = '0; dv = '0; bv = '0;
        for (int n = 0; n <= 23; n++) begin
            tick();
            lv[n] = line;
            dv[n] = done;
            bv[n] = busy;
            if (n == 0) i = 4'h4;
            if (n == 2) v = 1'b0;
        end
        chk("b2b_line", lv, {8'd0, 1'b1, 11'b11010001010, 11'b11001001010, 1'b1});
        chk("b2b_done", dv, 32'h0040_0800);
        chk("b2b_busy", bv, 32'h007F_FFFF);
        tick();
        chk("rx_disp_5", 32'(rx_disp), 32'h5);
        chk("rx_store_5", 32'(rx_store), 32'h5);

        // STRICT rejection of instr 3
        v = 1'b1; d = 4'h6; i = 4'h3;
        tick();
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_ready", 32'(ready), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        v = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (err !== 1'b0) cnt_a++;
            if (line !== 1'b1) cnt_b++;
        end
        chk("rej_err_once", 32'(cnt_a), 32'd0);
        chk("rej_line_high", 32'(cnt_b), 32'd0);
        chk("rej_ready_after", 32'(ready), 32'd1);
        chk("rej_rx_disp", 32'(rx_disp), 32'h5);

        // STRICT=0, STOP_CYCLES=5: (6,3) verbatim then (9,1) back-to-back
        v2 = 1'b1; d2 = 4'h6; i2 = 4'h3;
        lv = '0; dv = '0;
        for (int n = 0; n <= 29; n++) begin
            tick();
            lv[n] = line2;
            dv[n] = done2;
            if (n == 0) begin
                d2 = 4'h9;
                i2 = 4'h1;
            end
            if (n == 2) v2 = 1'b0;
        end
        chk("s5_line", lv, {2'b00, 1'b1, 14'b11111000110010, 14'b11111001101100, 1'b1});
        chk("s5_done", dv, 32'h1000_4000);
        chk("s5_err", 32'(err2), 32'd0);
        chk("s5_busy_fall", 32'(busy2), 32'd0);

        // Reset during instruction bit 1 with a second command buffered
        v = 1'b1; d = 4'h7; i = 4'h4;
        for (int n = 0; n <= 7; n++) begin
            tick();
            if (n == 0) d = 4'h9;
            if (n == 2) v = 1'b0;
        end
        chk("mid_instr_bit1", 32'(line), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 32'(line), 32'd1);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ready !== 1'b0) cnt_a++;
            if (line !== 1'b1) cnt_b++;
        end
        chk("rq_ready_low", 32'(cnt_a), 32'd0);
        chk("rq_line_high", 32'(cnt_b), 32'd0);
        tick();
        chk("rq_ready_rise", 32'(ready), 32'd1);
        chk("rq_buffer_lost", 32'(busy), 32'd0);
        chk("rq_rx_disp", 32'(rx_disp), 32'h5);

        // New command after reset
        v = 1'b1; d = 4'h3; i = 4'h4;
        tick();
        v = 1'b0;
        for (int n = 0; n < 13; n++) tick();
        chk("post_rst_disp_3", 32'(rx_disp), 32'h3);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
